sal_ref_sched: RTL

//  All-bank refresh scheduler for the DDR controller. Tracks elapsed tREFI intervals and keeps
//  a count of owed refreshes, which lets refreshes be postponed while traffic is pending.

---
 rtl/sal_ref_pkg.sv | 11 +
 rtl/sal_ref_intv_cnt.sv | 29 ++
 rtl/sal_ref_sched.sv | 127 ++++++++++++
 3 files changed

// File: rtl/sal_ref_pkg.sv
// Shared types and constants for the all-bank refresh path.
package sal_ref_pkg;

    typedef enum logic [1:0] {IDLE, REQ, CMD, WAIT_RFC} ref_state_t;

    // {ras_n, cas_n, we_n} for an all-bank REF command
    localparam logic [2:0] REF_OPCODE = 3'b001;

    localparam int unsigned OWED_W = 4;

endpackage

// File: rtl/sal_ref_intv_cnt.sv
// tREFI interval counter: counts 0..trefi-1 while enabled and pulses o_tick on the wrap cycle.
module sal_ref_intv_cnt #(
    parameter int unsigned TREFI_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_en,
    input  logic [TREFI_W-1:0] i_trefi,
    output logic               o_tick
);

    logic [TREFI_W-1:0] r_cnt;
    logic               w_run;
    logic               w_wrap;

    assign w_run  = i_en && (i_trefi != '0);
    // >= so a live shrink of trefi below the current count wraps at once
    assign w_wrap = r_cnt >= (i_trefi - TREFI_W'(1));
    assign o_tick = w_run && w_wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_run) begin
            r_cnt <= w_wrap ? '0 : r_cnt + TREFI_W'(1);
        end
    end

endmodule

// File: rtl/sal_ref_sched.sv
// All-bank refresh scheduler: owes refreshes per tREFI tick, parks all banks, issues one REF,
// holds the banks for tRFC and releases them.
module sal_ref_sched
    import sal_ref_pkg::*;
#(
    parameter int unsigned BK_CNT    = 4,
    parameter int unsigned TREFI_W   = 16,
    parameter int unsigned TRFC_W    = 10,
    parameter int unsigned MAX_OWED  = 8,
    parameter int unsigned URGENT_TH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ref_en_i,
    input  logic [TREFI_W-1:0] trefi_i,
    input  logic [TRFC_W-1:0]  trfc_i,
    input  logic               idle_i,
    output logic [BK_CNT-1:0]  bk_req_o,
    input  logic [BK_CNT-1:0]  bk_gnt_i,
    output logic               ref_valid_o,
    input  logic               ref_ready_i,
    output logic               busy_o,
    output logic               urgent_o,
    output logic [OWED_W-1:0]  owed_o,
    output logic               overflow_o
);

    localparam logic [OWED_W-1:0] LP_MAX_OWED  = OWED_W'(MAX_OWED);
    localparam logic [OWED_W-1:0] LP_URGENT_TH = OWED_W'(URGENT_TH);

    ref_state_t          r_state;
    logic [BK_CNT-1:0]   r_bk_req;
    logic                r_ref_valid;
    logic                r_busy;
    logic [TRFC_W-1:0]   r_rfc;
    logic [OWED_W-1:0]   r_owed;
    logic                r_overflow;

    logic                w_tick;
    logic                w_done;
    logic                w_start;
    logic [TRFC_W-1:0]   w_trfc_m1;

    sal_ref_intv_cnt #(
        .TREFI_W (TREFI_W)
    ) u_intv_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_en    (ref_en_i),
        .i_trefi (trefi_i),
        .o_tick  (w_tick)
    );

    assign w_trfc_m1 = (trfc_i == '0) ? '0 : trfc_i - TRFC_W'(1);
    assign w_done    = (r_state == WAIT_RFC) && (r_rfc == '0);
    assign w_start   = ref_en_i && (r_owed != '0) && (idle_i || (r_owed >= LP_URGENT_TH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_bk_req    <= '0;
            r_ref_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_rfc       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state  <= REQ;
                        r_bk_req <= '1;
                        r_busy   <= 1'b1;
                    end
                end
                REQ: begin
                    if (&bk_gnt_i) begin
                        r_state     <= CMD;
                        r_ref_valid <= 1'b1;
                    end
                end
                CMD: begin
                    if (r_ref_valid && ref_ready_i) begin
                        r_state     <= WAIT_RFC;
                        r_ref_valid <= 1'b0;
                        r_rfc       <= w_trfc_m1;
                    end
                end
                WAIT_RFC: begin
                    if (r_rfc == '0) begin
                        r_state  <= IDLE;
                        r_bk_req <= '0;
                        r_busy   <= 1'b0;
                    end else begin
                        r_rfc <= r_rfc - TRFC_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // A tick coinciding with done cancels out; saturation only when a tick is really lost
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owed     <= '0;
            r_overflow <= 1'b0;
        end else if (w_tick && !w_done) begin
            if (r_owed == LP_MAX_OWED) begin
                r_overflow <= 1'b1;
            end else begin
                r_owed <= r_owed + OWED_W'(1);
            end
        end else if (w_done && !w_tick) begin
            r_owed <= r_owed - OWED_W'(1);
        end
    end

    assign bk_req_o    = r_bk_req;
    assign ref_valid_o = r_ref_valid;
    assign busy_o      = r_busy;
    assign owed_o      = r_owed;
    assign urgent_o    = r_owed >= LP_URGENT_TH;
    assign overflow_o  = r_overflow;

    a_gnt_held: assert property (@(posedge clk) disable iff (rst)
        ((r_state == CMD) || (r_state == WAIT_RFC)) |-> (&bk_gnt_i));

endmodule
